// File: rtl/mdu_ctrl_pkg.sv
// Shared constants for the multiply/divide unit controller: op codes,
// default latencies, FSM state codes and a small op-class helper.
package mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int unsigned MUL_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF = 10;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic is_arith_op(logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_arith.sv
// Combinational multiply/divide datapath. Produces the HI/LO pair for the
// op presented; the controller latches it into pending registers at issue.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic [31:0] num, den, den_safe, quo, rem;
  logic        signed_div;

  // Signed divide runs on magnitudes so 0x80000000 / -1 needs no special
  // case: |a| = 0x80000000 fits unsigned and the quotient wraps to itself.
  always_comb begin
    a_sx       = {{32{a[31]}}, a};
    b_sx       = {{32{b[31]}}, b};
    prod_s     = a_sx * b_sx;
    prod_u     = {32'd0, a} * {32'd0, b};
    signed_div = (op == OP_DIV);
    num        = (signed_div && a[31]) ? (32'd0 - a) : a;
    den        = (signed_div && b[31]) ? (32'd0 - b) : b;
    div_zero   = (b == 32'd0);
    den_safe   = div_zero ? 32'd1 : den;
    quo        = num / den_safe;
    rem        = num % den_safe;
    res_hi     = 32'd0;
    res_lo     = 32'd0;
    case (op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        res_lo = (a[31] ^ b[31]) ? (32'd0 - quo) : quo;
        res_hi = a[31] ? (32'd0 - rem) : rem;
      end
      OP_DIVU: begin
        res_lo = quo;
        res_hi = rem;
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: IDLE/RUN FSM with a down-counter that models the
// multi-cycle multiply/divide latency, HI/LO architectural registers,
// and the pipeline stall for a following MDU instruction in D.
// Handshake: an op is accepted only when op_valid is high in IDLE; while
// busy every op_valid is dropped, and the pipeline is held off by stall.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_data,
  output mdu_state_e  dbg_state
);

  mdu_state_e  state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;

  logic [31:0] res_hi, res_lo;
  logic        div_zero, start, is_div;

  mdu_arith u_arith (
    .op       (mdu_op),
    .a        (rs_val),
    .b        (rt_val),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  assign is_div = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);
  assign start  = op_valid && (state_q == ST_IDLE) && is_arith_op(mdu_op);

  // Next-state: issue latches the result as pending, RUN counts down and
  // commits pending to HI/LO on the edge that ends the count==1 cycle.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          count_d   = is_div ? 4'(DIV_LAT) : 4'(MUL_LAT);
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          // A zero divisor still burns the full latency but commits nothing.
          pend_wr_d = !(is_div && div_zero);
        end else if (op_valid && (mdu_op == OP_MTHI)) begin
          hi_d = rs_val;
        end else if (op_valid && (mdu_op == OP_MTLO)) begin
          lo_d = rs_val;
        end
      end
      ST_RUN: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          state_d = ST_IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and register update; reset discards any pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  // Move-from returns the committed registers, never the pending result.
  always_comb begin
    mf_data = 32'd0;
    if (mdu_op == OP_MFHI) mf_data = hi_q;
    else if (mdu_op == OP_MFLO) mf_data = lo_q;
  end

  assign busy      = (state_q == ST_RUN);
  assign stall     = d_md_use & (busy | start);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl with a cycle-level reference model.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        d_md_use = 1'b0;
  logic [3:0]  mdu_op = 4'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        busy, stall;
  logic [31:0] hi, lo, mf_data;
  mdu_state_e  dbg_state;

  always #5 clk = ~clk;

  mdu_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .mdu_op(mdu_op),
    .rs_val(rs_val), .rt_val(rt_val), .d_md_use(d_md_use),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo), .mf_data(mf_data),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model / scoreboard ----------------
  // m_left = busy cycles still to come (including the current one);
  // exp_q holds the {HI,LO} result of the operation in flight.
  logic [31:0] m_hi, m_lo;
  int          m_left;
  bit          m_write;
  logic [63:0] exp_q[$];
  logic        exp_busy, exp_stall;
  logic [31:0] exp_mf;
  logic [97:0] expv;
  wire  [97:0] obs = {busy, stall, mf_data, hi, lo};

  function automatic bit arith(logic [3:0] op);
    return op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU;
  endfunction

  function automatic logic [63:0] ref_result(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 64'd0;
    case (op)
      OP_MULT:  r = sa * sb;
      OP_MULTU: r = {32'd0, a} * {32'd0, b};
      OP_DIV:   if (b != 0) r = {32'(sa % sb), 32'(sa / sb)};
      OP_DIVU:  if (b != 0) r = {a % b, a / b};
      default:  r = 64'd0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_write = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // Drive one cycle's inputs (just after a rising edge) and form expectations.
  task automatic drive(bit v, logic [3:0] op, logic [31:0] a, logic [31:0] b, bit du);
    op_valid = v; mdu_op = op; rs_val = a; rt_val = b; d_md_use = du;
    #1;
    exp_busy  = (m_left > 0);
    exp_stall = du && (exp_busy || (v && m_left == 0 && arith(op)));
    exp_mf    = (op == OP_MFHI) ? m_hi : (op == OP_MFLO) ? m_lo : 32'd0;
    expv      = {exp_busy, exp_stall, exp_mf, m_hi, m_lo};
  endtask

  // Advance the model across the rising edge, then the clock itself.
  task automatic tick();
    logic [63:0] r;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        r = exp_q.pop_front();
        if (m_write) begin m_hi = r[63:32]; m_lo = r[31:0]; end
      end
    end else if (op_valid && arith(mdu_op)) begin
      exp_q.push_back(ref_result(mdu_op, rs_val, rt_val));
      m_write = !((mdu_op == OP_DIV || mdu_op == OP_DIVU) && rt_val == 0);
      m_left  = (mdu_op == OP_MULT || mdu_op == OP_MULTU) ? MUL_LAT : DIV_LAT;
    end else if (op_valid && mdu_op == OP_MTHI) begin
      m_hi = rs_val;
    end else if (op_valid && mdu_op == OP_MTLO) begin
      m_lo = rs_val;
    end
    @(posedge clk);
    #1;
  endtask

  // Issue one op then idle; report per-cycle model disagreement and counts.
  task automatic run_op(logic [3:0] op, logic [31:0] a, logic [31:0] b, bit du, int cycles,
                        output int busy_cnt, output int stall_cnt, output int bad_cnt);
    busy_cnt = 0; stall_cnt = 0; bad_cnt = 0;
    for (int i = 0; i <= cycles; i++) begin
      if (i == 0) drive(1'b1, op, a, b, du);
      else        drive(1'b0, OP_NONE, 32'd0, 32'd0, du);
      if (obs !== expv) bad_cnt++;
      if (busy === 1'b1) busy_cnt++;
      if (stall === 1'b1) stall_cnt++;
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    model_reset();
    drive(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    n_checks++;
    if ({busy, hi, lo, dbg_state} !== {1'b0, 64'd0, ST_IDLE})
      $display("FAIL reset_state: got busy=%b hi=%h lo=%h st=%0d expected all zero", busy, hi, lo, dbg_state);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    // First edge after reset release must accept a start.
    drive(1'b1, OP_MULT, 32'd3, 32'd4, 1'b0);
    tick();
    drive(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL first_start: got busy=%b expected 1", busy);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (obs !== expv) $display("FAIL first_start_cyc%0d: got %h expected %h", i, obs, expv);
      else n_pass++;
      tick();
      drive(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    end
    n_checks++;
    if (lo !== 32'd12) $display("FAIL first_start_lo: got %h expected 0000000c", lo);
    else n_pass++;
  endtask

  task automatic test_mult();
    int bc, sc, bad;
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, 7, bc, sc, bad);
    n_checks++;
    if ({bc, hi, lo, bad} !== {32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0})
      $display("FAIL mult: got busy_cyc=%0d hi=%h lo=%h bad=%0d expected 5 ffffffff fffffffe 0", bc, hi, lo, bad);
    else n_pass++;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 7, bc, sc, bad);
    n_checks++;
    if ({bc, hi, lo, bad} !== {32'd5, 32'h0000_0001, 32'hFFFF_FFFE, 32'd0})
      $display("FAIL multu: got busy_cyc=%0d hi=%h lo=%h bad=%0d expected 5 00000001 fffffffe 0", bc, hi, lo, bad);
    else n_pass++;
  endtask

  task automatic test_div_stall();
    int bc, sc, bad;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 13, bc, sc, bad);
    n_checks++;
    if ({bc, sc, bad} !== {32'd10, 32'd11, 32'd0})
      $display("FAIL div_stall: got busy_cyc=%0d stall_cyc=%0d bad=%0d expected 10 11 0", bc, sc, bad);
    else n_pass++;
    n_checks++;
    if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD})
      $display("FAIL div_result: got hi=%h lo=%h expected ffffffff fffffffd", hi, lo);
    else n_pass++;
  endtask

  task automatic test_div_zero();
    int bc, sc, bad;
    drive(1'b1, OP_MTHI, 32'h11, 32'd0, 1'b0); tick();
    drive(1'b1, OP_MTLO, 32'h22, 32'd0, 1'b0); tick();
    run_op(OP_DIVU, 32'd5, 32'd0, 1'b0, 12, bc, sc, bad);
    n_checks++;
    if ({bc, hi, lo, bad} !== {32'd10, 32'h11, 32'h22, 32'd0})
      $display("FAIL divu_zero: got busy_cyc=%0d hi=%h lo=%h bad=%0d expected 10 00000011 00000022 0", bc, hi, lo, bad);
    else n_pass++;
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 12, bc, sc, bad);
    n_checks++;
    if ({hi, lo, bad} !== {32'h0, 32'h8000_0000, 32'd0})
      $display("FAIL div_intmin: got hi=%h lo=%h bad=%0d expected 00000000 80000000 0", hi, lo, bad);
    else n_pass++;
  endtask

  task automatic test_mt_mf();
    drive(1'b1, OP_MTLO, 32'hABCD, 32'd0, 1'b0); tick();
    drive(1'b1, OP_MFLO, 32'd0, 32'd0, 1'b0);
    n_checks++;
    if ({lo, mf_data} !== {32'hABCD, 32'hABCD})
      $display("FAIL mtlo_mflo: got lo=%h mf=%h expected 0000abcd 0000abcd", lo, mf_data);
    else n_pass++;
    tick();
    // MTHI and a second MULT during RUN are both dropped.
    drive(1'b1, OP_MULT, 32'd3, 32'd7, 1'b0); tick();
    drive(1'b1, OP_MTHI, 32'h5555, 32'd0, 1'b1);
    n_checks++;
    if (obs !== expv) $display("FAIL mthi_busy: got %h expected %h", obs, expv);
    else n_pass++;
    tick();
    drive(1'b1, OP_MULT, 32'd100, 32'd100, 1'b0); tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0); tick();
    end
    n_checks++;
    if ({busy, hi, lo} !== {1'b0, 32'd0, 32'd21})
      $display("FAIL ignore_busy: got busy=%b hi=%h lo=%h expected 0 00000000 00000015", busy, hi, lo);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    drive(1'b1, OP_MULT, 32'h12345, 32'h6789, 1'b0); tick();
    drive(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0); tick();
    drive(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0); tick();
    drive(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, hi, lo} !== {1'b0, 64'd0})
      $display("FAIL reset_async: got busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
    else n_pass++;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0); tick();
    end
    n_checks++;
    if ({busy, hi, lo} !== {1'b0, 64'd0})
      $display("FAIL reset_no_late_write: got busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int bc, sc, bad, n;
    bit fell;
    drive(1'b1, OP_MULT, 32'd6, 32'd7, 1'b0); tick();
    fell = 1'b0;
    n = 0;
    while (!fell && n < 20) begin
      drive(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
      if (busy === 1'b0) fell = 1'b1;
      else begin tick(); n++; end
    end
    n_checks++;
    if (!fell || lo !== 32'd42)
      $display("FAIL b2b_mult: got fell=%b lo=%h after %0d cycles expected 1 0000002a", fell, lo, n);
    else n_pass++;
    run_op(OP_DIV, 32'd100, 32'd7, 1'b0, 12, bc, sc, bad);
    n_checks++;
    if ({bc, hi, lo, bad} !== {32'd10, 32'd2, 32'd14, 32'd0})
      $display("FAIL b2b_div: got busy_cyc=%0d hi=%h lo=%h bad=%0d expected 10 00000002 0000000e 0", bc, hi, lo, bad);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] specials[5];
    logic [31:0] a, b;
    logic [3:0]  op;
    int bad;
    specials = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd7};
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 8));
      a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom();
      b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom();
      drive($urandom_range(0, 3) != 0, op, a, b, 1'($urandom_range(0, 1)));
      n_checks++;
      if (obs !== expv) begin
        if (bad < 5) $display("FAIL random_cyc%0d: got %h expected %h", i, obs, expv);
        bad++;
      end else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_stall();
    test_div_zero();
    test_mt_mf();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
